// File: rtl/bus_mailbox_device.sv
// Device-side mailbox: word FIFO behind DATA/STATUS/CTRL regs, 1-cycle response.
// Optional BUS_MAILBOX_IRQ_EN adds irq_o and the CTRL irq_en bit.
module bus_mailbox_device #(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddressWidth = 32,
    parameter int unsigned Depth        = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      device_req_i,
    input  logic [AddressWidth-1:0]   device_addr_i,
    input  logic                      device_we_i,
    input  logic [DataWidth/8-1:0]    device_be_i,
    input  logic [DataWidth-1:0]      device_wdata_i,
    output logic                      device_rvalid_o,
    output logic [DataWidth-1:0]      device_rdata_o,
    output logic                      device_err_o
`ifdef BUS_MAILBOX_IRQ_EN
    ,
    output logic                      irq_o
`endif
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned LvlW = PtrW + 1;

    logic [DataWidth-1:0] mem_q [Depth];
    logic [PtrW-1:0]      wptr_q, wptr_d;
    logic [PtrW-1:0]      rptr_q, rptr_d;
    logic [LvlW-1:0]      level_q, level_d;
    logic                 irq_en_q, irq_en_d;
    logic                 rvalid_q;
    logic [DataWidth-1:0] rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic                 push;
    logic                 full, empty;

    logic unused_addr;
    assign unused_addr = ^{device_addr_i[AddressWidth-1:4], device_addr_i[1:0]};

    assign full  = (level_q == LvlW'(Depth));
    assign empty = (level_q == '0);

    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        level_d  = level_q;
        irq_en_d = irq_en_q;
        push     = 1'b0;
        rdata_d  = '0;
        err_d    = 1'b0;
        if (device_req_i) begin
            unique case (device_addr_i[3:2])
                2'd0: begin
                    if (device_we_i) begin
                        if (!(&device_be_i) || full) begin
                            err_d = 1'b1;
                        end else begin
                            push    = 1'b1;
                            wptr_d  = wptr_q + PtrW'(1);
                            level_d = level_q + LvlW'(1);
                        end
                    end else if (empty) begin
                        err_d = 1'b1;
                    end else begin
                        rdata_d = mem_q[rptr_q];
                        rptr_d  = rptr_q + PtrW'(1);
                        level_d = level_q - LvlW'(1);
                    end
                end
                2'd1: begin
                    if (device_we_i) begin
                        err_d = 1'b1;
                    end else begin
                        rdata_d[8 +: LvlW] = level_q;
                        rdata_d[1]         = full;
                        rdata_d[0]         = empty;
                    end
                end
                2'd2: begin
                    if (device_we_i) begin
                        if (device_be_i[0]) begin
                            if (device_wdata_i[0]) begin
                                wptr_d  = '0;
                                rptr_d  = '0;
                                level_d = '0;
                            end
`ifdef BUS_MAILBOX_IRQ_EN
                            irq_en_d = device_wdata_i[1];
`endif
                        end
                    end else begin
                        rdata_d[1] = irq_en_q;
                    end
                end
                default: err_d = 1'b1;
            endcase
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= device_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
            irq_en_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            level_q  <= level_d;
            irq_en_q <= irq_en_d;
            rvalid_q <= device_req_i;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign device_rvalid_o = rvalid_q;
    assign device_rdata_o  = rdata_q;
    assign device_err_o    = err_q;

`ifdef BUS_MAILBOX_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_en_d & (level_d != '0);
        end
    end

    assign irq_o = irq_q;
`endif

endmodule

// File: tb/tb_bus_mailbox_device.sv
// Scoreboard bench for bus_mailbox_device against a queue-based mailbox model.
// Covers the irq path too when BUS_MAILBOX_IRQ_EN is defined.
module tb_bus_mailbox_device;

    localparam int DEPTH = 8;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req = 1'b0;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    logic [3:0]  be = '0;
    logic [31:0] wdata = '0;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
`ifdef BUS_MAILBOX_IRQ_EN
    logic        irq;
`endif

    bus_mailbox_device #(
        .DataWidth(32), .AddressWidth(32), .Depth(DEPTH)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .device_req_i(req),
        .device_addr_i(addr),
        .device_we_i(we),
        .device_be_i(be),
        .device_wdata_i(wdata),
        .device_rvalid_o(rvalid),
        .device_rdata_o(rdata),
        .device_err_o(err)
`ifdef BUS_MAILBOX_IRQ_EN
        ,
        .irq_o(irq)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        irq;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mq[$];
    bit          m_irq_en = 1'b0;
    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;

    always @(posedge clk_i) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)",
                      name, act, exp, cyc);
    endtask

    // Response monitor: every cycle either pops a due expectation or
    // requires an idle bus.
    always @(negedge clk_i) begin
        exp_t e;
        if (rst_ni) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                chk("rvalid", {31'b0, rvalid}, 32'd1);
                chk("rdata", rdata, e.rdata);
                chk("err", {31'b0, err}, {31'b0, e.err});
`ifdef BUS_MAILBOX_IRQ_EN
                chk("irq", {31'b0, irq}, {31'b0, e.irq});
`endif
            end else begin
                chk("idle_rsp", {rdata[31:2], rvalid, err}, 32'd0);
            end
        end
    end

    task automatic access(input logic w, input logic [31:0] a,
                          input logic [3:0] b, input logic [31:0] d);
        exp_t e;
        e.rdata = '0;
        e.err   = 1'b0;
        case (a[3:2])
            2'd0: begin
                if (w) begin
                    if (b != 4'hF || mq.size() == DEPTH) e.err = 1'b1;
                    else mq.push_back(d);
                end else if (mq.size() == 0) begin
                    e.err = 1'b1;
                end else begin
                    e.rdata = mq.pop_front();
                end
            end
            2'd1: begin
                if (w) e.err = 1'b1;
                else e.rdata = (32'(mq.size()) * 256)
                             + ((mq.size() == DEPTH) ? 32'd2 : 32'd0)
                             + ((mq.size() == 0) ? 32'd1 : 32'd0);
            end
            2'd2: begin
                if (w) begin
                    if (b[0]) begin
                        if (d[0]) mq.delete();
`ifdef BUS_MAILBOX_IRQ_EN
                        m_irq_en = d[1];
`endif
                    end
                end else begin
                    e.rdata = m_irq_en ? 32'd2 : 32'd0;
                end
            end
            default: e.err = 1'b1;
        endcase
        e.irq = m_irq_en && (mq.size() != 0);
        e.due = cyc + 1;
        sb.push_back(e);
        req   = 1'b1;
        we    = w;
        addr  = a;
        be    = b;
        wdata = d;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        we  = 1'b0;
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic status();
        access(1'b0, 32'h4, 4'hF, 32'h0);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        int          sel;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        status();
        for (int i = 1; i <= 8; i++) access(1'b1, 32'h0, 4'hF, 32'hA5A5_0000 + 32'(i));
        status();
        access(1'b1, 32'h0, 4'hF, 32'hDEAD_BEEF);
        status();
        for (int i = 0; i < 9; i++) access(1'b0, 32'h0, 4'hF, 32'h0);
        status();
        idle(2);

        for (int i = 0; i < 5; i++) access(1'b1, 32'h0, 4'hF, 32'h1000 + 32'(i));
        for (int i = 0; i < 5; i++) access(1'b0, 32'h0, 4'hF, 32'h0);
        for (int i = 0; i < 6; i++) access(1'b1, 32'h0, 4'hF, 32'h2000 + 32'(i));
        for (int i = 0; i < 6; i++) access(1'b0, 32'h0, 4'hF, 32'h0);
        status();

        access(1'b1, 32'h0, 4'b0011, 32'h1234_5678);
        status();
        access(1'b0, 32'hC, 4'hF, 32'h0);
        access(1'b1, 32'hC, 4'hF, 32'h5);
        access(1'b1, 32'h4, 4'hF, 32'h0);
        for (int i = 0; i < 3; i++) access(1'b1, 32'h0, 4'hF, 32'h3000 + 32'(i));
        access(1'b1, 32'h8, 4'hF, 32'h1);
        status();
        access(1'b1, 32'h0, 4'hF, 32'h4444);
        access(1'b1, 32'h8, 4'hE, 32'h1);
        status();
        access(1'b1, 32'h8, 4'hF, 32'h1);
        idle(2);

        access(1'b1, 32'h8, 4'hF, 32'h2);
        access(1'b0, 32'h8, 4'hF, 32'h0);
        access(1'b1, 32'h0, 4'hF, 32'hCAFE_0001);
        idle(2);
        access(1'b0, 32'h0, 4'hF, 32'h0);
        idle(2);

        access(1'b1, 32'h0, 4'hF, 32'h7);
        access(1'b1, 32'h0, 4'hF, 32'h8);
        req    = 1'b0;
        rst_ni = 1'b0;
        #1;
        chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
`ifdef BUS_MAILBOX_IRQ_EN
        chk("rst_irq", {31'b0, irq}, 32'd0);
`endif
        sb.delete();
        mq.delete();
        m_irq_en = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        status();

        for (int i = 0; i < 400; i++) begin
            r   = $urandom;
            sel = $urandom_range(0, 11);
            if (sel == 11) begin
                idle(1);
            end else begin
                a = {r[31:4], 4'b0000} | 32'(r[1:0]);
                if (sel <= 5) a[3:2] = 2'd0;
                else if (sel <= 7) a[3:2] = 2'd1;
                else if (sel == 8) a[3:2] = 2'd2;
                else a[3:2] = 2'd3;
                r = $urandom;
                if (a[3:2] == 2'd2) r[0] = ($urandom_range(0, 3) == 0);
                access(($urandom_range(0, 1) == 1),
                       a,
                       ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF,
                       r);
            end
        end
        idle(3);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
